// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage.
//  - ALU opcode encoding (must match the combinational ALU downstream)
//  - MIPS primary opcode and R-type funct codes understood by the decoder
//  - operand-select enums, decoder result struct, slot FSM state
package alu_issue_stage_pkg;

  localparam int REG_W   = 32;
  localparam int RADDR_W = 5;

  // ALU opcodes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDU = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SUBU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_SLL  = 4'd10;
  localparam logic [3:0] ALU_SRL  = 4'd11;
  localparam logic [3:0] ALU_SRA  = 4'd12;

  // MIPS primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // B operand source
  typedef enum logic [1:0] {B_RT, B_SEXT, B_ZEXT} b_sel_t;
  // Shift amount source
  typedef enum logic [1:0] {SA_NONE, SA_SHAMT, SA_RS, SA_16} sa_sel_t;
  // Issue slot occupancy
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

  typedef struct packed {
    logic [3:0]         op;
    b_sel_t             b_sel;
    sa_sel_t            sa_sel;
    logic [RADDR_W-1:0] wr_reg;
    logic               reg_write;
    logic               illegal;
  } dec_t;

endpackage

// File: rtl/alu_issue_stage_decode.sv
// alu_decode: purely combinational MIPS decode.
//  i_opcode/i_funct  instruction op and funct fields
//  i_rt/i_rd         register index fields
//  o_dec             ALU op, operand/shift selects, destination, write enable, illegal
// Illegal encodings decode to a harmless ADDU with no write-back.
module alu_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [5:0]         i_opcode,
  input  logic [5:0]         i_funct,
  input  logic [RADDR_W-1:0] i_rt,
  input  logic [RADDR_W-1:0] i_rd,
  output dec_t               o_dec
);

  logic [3:0]         w_op;
  b_sel_t             w_b_sel;
  sa_sel_t            w_sa_sel;
  logic [RADDR_W-1:0] w_wr;
  logic               w_we;
  logic               w_bad;

  always_comb begin
    w_op     = ALU_ADDU;
    w_b_sel  = B_RT;
    w_sa_sel = SA_NONE;
    w_wr     = i_rt;
    w_we     = 1'b1;
    w_bad    = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        w_wr = i_rd;
        case (i_funct)
          FN_ADD:  w_op = ALU_ADD;
          FN_ADDU: w_op = ALU_ADDU;
          FN_SUB:  w_op = ALU_SUB;
          FN_SUBU: w_op = ALU_SUBU;
          FN_AND:  w_op = ALU_AND;
          FN_OR:   w_op = ALU_OR;
          FN_XOR:  w_op = ALU_XOR;
          FN_NOR:  w_op = ALU_NOR;
          FN_SLT:  w_op = ALU_SLT;
          FN_SLTU: w_op = ALU_SLTU;
          FN_SLL:  begin w_op = ALU_SLL; w_sa_sel = SA_SHAMT; end
          FN_SRL:  begin w_op = ALU_SRL; w_sa_sel = SA_SHAMT; end
          FN_SRA:  begin w_op = ALU_SRA; w_sa_sel = SA_SHAMT; end
          FN_SLLV: begin w_op = ALU_SLL; w_sa_sel = SA_RS; end
          FN_SRLV: begin w_op = ALU_SRL; w_sa_sel = SA_RS; end
          FN_SRAV: begin w_op = ALU_SRA; w_sa_sel = SA_RS; end
          default: w_bad = 1'b1;
        endcase
      end
      OP_ADDI:  begin w_op = ALU_ADD;  w_b_sel = B_SEXT; end
      OP_ADDIU: begin w_op = ALU_ADDU; w_b_sel = B_SEXT; end
      OP_SLTI:  begin w_op = ALU_SLT;  w_b_sel = B_SEXT; end
      OP_SLTIU: begin w_op = ALU_SLTU; w_b_sel = B_SEXT; end
      OP_ANDI:  begin w_op = ALU_AND;  w_b_sel = B_ZEXT; end
      OP_ORI:   begin w_op = ALU_OR;   w_b_sel = B_ZEXT; end
      OP_XORI:  begin w_op = ALU_XOR;  w_b_sel = B_ZEXT; end
      // LUI reuses the shifter: imm << 16
      OP_LUI:   begin w_op = ALU_SLL;  w_b_sel = B_ZEXT; w_sa_sel = SA_16; end
      OP_LW:    begin w_op = ALU_ADDU; w_b_sel = B_SEXT; end
      OP_SW:    begin w_op = ALU_ADDU; w_b_sel = B_SEXT; w_we = 1'b0; end
      OP_BEQ,
      OP_BNE:   begin w_op = ALU_SUBU; w_we = 1'b0; end
      default:  w_bad = 1'b1;
    endcase
    if (w_bad) begin
      w_op     = ALU_ADDU;
      w_b_sel  = B_RT;
      w_sa_sel = SA_NONE;
      w_wr     = '0;
      w_we     = 1'b0;
    end
    // $zero is never a real destination
    if (w_wr == '0) w_we = 1'b0;
  end

  assign o_dec = '{op: w_op, b_sel: w_b_sel, sa_sel: w_sa_sel,
                   wr_reg: w_wr, reg_write: w_we, illegal: w_bad};

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX slot feeding the combinational ALU.
//  clk, rst_n              clock, synchronous active-low reset
//  in_valid/in_ready       upstream handshake carrying instr, rs_val, rt_val
//  flush                   kills the slot and the instruction offered this cycle
//  out_valid/out_ready     downstream (EX) handshake
//  alu_op/alu_a/alu_b/alu_sa  registered ALU inputs
//  wr_reg/reg_write/illegal   registered write-back info and decode error flag
//  dbg_slot_state          slot FSM state for observation
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Producers hold valid and data until accepted; in_ready = !out_valid || out_ready,
// so a full slot accepts only when it is drained in the same cycle. While out_valid
// is high and out_ready is low, every output is held.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [REG_W-1:0]   instr,
  input  logic [REG_W-1:0]   rs_val,
  input  logic [REG_W-1:0]   rt_val,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         alu_op,
  output logic [REG_W-1:0]   alu_a,
  output logic [REG_W-1:0]   alu_b,
  output logic [4:0]         alu_sa,
  output logic [RADDR_W-1:0] wr_reg,
  output logic               reg_write,
  output logic               illegal,
  output slot_state_t        dbg_slot_state
);

  dec_t               w_dec;
  logic [REG_W-1:0]   w_a;
  logic [REG_W-1:0]   w_b;
  logic [4:0]         w_sa;
  logic               w_accept;
  logic               w_load;
  slot_state_t        r_state;
  slot_state_t        w_state_nxt;
  logic               w_unused_rs;

  logic [3:0]         r_alu_op;
  logic [REG_W-1:0]   r_alu_a;
  logic [REG_W-1:0]   r_alu_b;
  logic [4:0]         r_alu_sa;
  logic [RADDR_W-1:0] r_wr_reg;
  logic               r_reg_write;
  logic               r_illegal;

  // Register indices for rs were resolved upstream; only its forwarded value is used.
  assign w_unused_rs = ^instr[25:21];

  alu_decode u_decode (
    .i_opcode (instr[31:26]),
    .i_funct  (instr[5:0]),
    .i_rt     (instr[20:16]),
    .i_rd     (instr[15:11]),
    .o_dec    (w_dec)
  );

  always_comb begin
    w_b = rt_val;
    case (w_dec.b_sel)
      B_SEXT:  w_b = {{16{instr[15]}}, instr[15:0]};
      B_ZEXT:  w_b = {16'b0, instr[15:0]};
      default: w_b = rt_val;
    endcase
    w_sa = 5'd0;
    case (w_dec.sa_sel)
      SA_SHAMT: w_sa = instr[10:6];
      SA_RS:    w_sa = rs_val[4:0];
      SA_16:    w_sa = 5'd16;
      default:  w_sa = 5'd0;
    endcase
    w_a = rs_val;
    // Illegal instructions flow through as 0 + 0
    if (w_dec.illegal) begin
      w_a = '0;
      w_b = '0;
    end
  end

  assign out_valid = (r_state == SLOT_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= SLOT_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // flush wins over both accept and hold; data regs are only loaded on a kept accept
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (flush) begin
      w_state_nxt = SLOT_EMPTY;
    end else begin
      case (r_state)
        SLOT_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = SLOT_FULL;
            w_load      = 1'b1;
          end
        end
        SLOT_FULL: begin
          if (out_ready) begin
            w_state_nxt = w_accept ? SLOT_FULL : SLOT_EMPTY;
            w_load      = w_accept;
          end
        end
        default: w_state_nxt = SLOT_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_op    <= ALU_ADDU;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sa    <= '0;
      r_wr_reg    <= '0;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_load) begin
      r_alu_op    <= w_dec.op;
      r_alu_a     <= w_a;
      r_alu_b     <= w_b;
      r_alu_sa    <= w_sa;
      r_wr_reg    <= w_dec.wr_reg;
      r_reg_write <= w_dec.reg_write;
      r_illegal   <= w_dec.illegal;
    end
  end

  assign alu_op         = r_alu_op;
  assign alu_a          = r_alu_a;
  assign alu_b          = r_alu_b;
  assign alu_sa         = r_alu_sa;
  assign wr_reg         = r_wr_reg;
  assign reg_write      = r_reg_write;
  assign illegal        = r_illegal;
  assign dbg_slot_state = r_state;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic        reg_write, illegal;
  logic [31:0] instr, rs_val, rt_val, alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  alu_sa, wr_reg;
  slot_state_t dbg_slot_state;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sa(alu_sa), .wr_reg(wr_reg),
    .reg_write(reg_write), .illegal(illegal), .dbg_slot_state(dbg_slot_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    logic [4:0]  wr;
    logic        we;
    logic        ill;
    logic [31:0] res;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [5:0] legal_ops [0:11] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                                   6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
  logic [5:0] legal_fns [0:15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                   6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                   6'h26, 6'h27, 6'h2A, 6'h2B};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // The downstream ALU: turns issued op/A/B/sa into a result
  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] sa);
    case (op)
      ALU_ADD, ALU_ADDU: return a + b;
      ALU_SUB, ALU_SUBU: return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return b << sa;
      ALU_SRL:  return b >> sa;
      ALU_SRA:  return $unsigned($signed(b) >>> sa);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Instruction semantics: what the issued slot must contain and what the ALU must compute
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [31:0] sx, zx;
    logic [4:0]  sh;
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'b0, ins[15:0]};
    sh = ins[10:6];
    e = '0;
    e.a = rs; e.b = rt; e.wr = ins[20:16]; e.we = 1'b1; e.op = ALU_ADDU;
    case (ins[31:26])
      6'h00: begin
        e.wr = ins[15:11];
        case (ins[5:0])
          6'h20: begin e.op = ALU_ADD;  e.res = rs + rt; end
          6'h21: begin e.op = ALU_ADDU; e.res = rs + rt; end
          6'h22: begin e.op = ALU_SUB;  e.res = rs - rt; end
          6'h23: begin e.op = ALU_SUBU; e.res = rs - rt; end
          6'h24: begin e.op = ALU_AND;  e.res = rs & rt; end
          6'h25: begin e.op = ALU_OR;   e.res = rs | rt; end
          6'h26: begin e.op = ALU_XOR;  e.res = rs ^ rt; end
          6'h27: begin e.op = ALU_NOR;  e.res = ~(rs | rt); end
          6'h2A: begin e.op = ALU_SLT;  e.res = {31'b0, $signed(rs) < $signed(rt)}; end
          6'h2B: begin e.op = ALU_SLTU; e.res = {31'b0, rs < rt}; end
          6'h00: begin e.op = ALU_SLL; e.sa = sh; e.res = rt << sh; end
          6'h02: begin e.op = ALU_SRL; e.sa = sh; e.res = rt >> sh; end
          6'h03: begin e.op = ALU_SRA; e.sa = sh; e.res = $unsigned($signed(rt) >>> sh); end
          6'h04: begin e.op = ALU_SLL; e.sa = rs[4:0]; e.res = rt << rs[4:0]; end
          6'h06: begin e.op = ALU_SRL; e.sa = rs[4:0]; e.res = rt >> rs[4:0]; end
          6'h07: begin e.op = ALU_SRA; e.sa = rs[4:0]; e.res = $unsigned($signed(rt) >>> rs[4:0]); end
          default: e.ill = 1'b1;
        endcase
      end
      6'h08: begin e.op = ALU_ADD;  e.b = sx; e.res = rs + sx; end
      6'h09: begin e.op = ALU_ADDU; e.b = sx; e.res = rs + sx; end
      6'h0A: begin e.op = ALU_SLT;  e.b = sx; e.res = {31'b0, $signed(rs) < $signed(sx)}; end
      6'h0B: begin e.op = ALU_SLTU; e.b = sx; e.res = {31'b0, rs < sx}; end
      6'h0C: begin e.op = ALU_AND;  e.b = zx; e.res = rs & zx; end
      6'h0D: begin e.op = ALU_OR;   e.b = zx; e.res = rs | zx; end
      6'h0E: begin e.op = ALU_XOR;  e.b = zx; e.res = rs ^ zx; end
      6'h0F: begin e.op = ALU_SLL;  e.b = zx; e.sa = 5'd16; e.res = {ins[15:0], 16'b0}; end
      6'h23: begin e.op = ALU_ADDU; e.b = sx; e.res = rs + sx; end
      6'h2B: begin e.op = ALU_ADDU; e.b = sx; e.res = rs + sx; e.we = 1'b0; end
      6'h04, 6'h05: begin e.op = ALU_SUBU; e.res = rs - rt; e.we = 1'b0; end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.op = ALU_ADDU; e.a = '0; e.b = '0; e.we = 1'b0; e.res = '0;
    end
    if (e.wr == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom();
    k = $urandom_range(0, 19);
    if (k < 7) begin
      w[31:26] = 6'h00;
      w[5:0]   = legal_fns[$urandom_range(0, 15)];
    end else if (k < 18) begin
      w[31:26] = legal_ops[$urandom_range(0, 11)];
    end
    if ($urandom_range(0, 9) == 0) w[20:11] = '0;  // exercise $zero destinations
    return w;
  endfunction

  task automatic check_outputs();
    exp_t e;
    logic full;
    full = (exp_q.size() != 0);
    check("in_ready", in_ready, !full || out_ready);
    check("out_valid", out_valid, full);
    check("dbg_state", dbg_slot_state, full ? SLOT_FULL : SLOT_EMPTY);
    if (full) begin
      e = exp_t'(exp_q[0]);
      check("alu_op", alu_op, e.op);
      check("alu_a", alu_a, e.a);
      check("alu_b", alu_b, e.b);
      check("reg_write", reg_write, e.we);
      check("illegal", illegal, e.ill);
      check("alu_res", alu(alu_op, alu_a, alu_b, alu_sa), e.res);
      if (!e.ill) begin
        check("alu_sa", alu_sa, e.sa);
        check("wr_reg", wr_reg, e.wr);
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; drives one cycle, checks, advances the model, returns at next falling edge.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input logic fl, input logic ordy);
    logic full, acc;
    in_valid = iv; instr = ins; rs_val = rs; rt_val = rt; flush = fl; out_ready = ordy;
    #1;
    check_outputs();
    full = (exp_q.size() != 0);
    acc  = iv && (!full || ordy);
    if (!rst_n || fl) begin
      exp_q.delete();
    end else begin
      if (full && ordy) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(EXP_W'(model(ins, rs, rt)));
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    cycle(1'b1, ins, rs, rt, 1'b0, 1'b1);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, ordy);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; rs_val = '0; rt_val = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_alu_op", alu_op, ALU_ADDU);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_b", alu_b, 32'h0);
    check("rst_alu_sa", alu_sa, 5'd0);
    check("rst_wr_reg", wr_reg, 5'd0);
    check("rst_reg_write", reg_write, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // ADDI $t0,$t1,-1 with rs=5
    issue(32'h2128FFFF, 32'd5, 32'd0);
    check("addi_op", alu_op, ALU_ADD);
    check("addi_b", alu_b, 32'hFFFF_FFFF);
    check("addi_wr", wr_reg, 5'd8);
    check("addi_res", alu(alu_op, alu_a, alu_b, alu_sa), 32'd4);

    // LUI $t0,0x1234
    issue(32'h3C081234, 32'h0, 32'h0);
    check("lui_op", alu_op, ALU_SLL);
    check("lui_b", alu_b, 32'h0000_1234);
    check("lui_sa", alu_sa, 5'd16);
    check("lui_res", alu(alu_op, alu_a, alu_b, alu_sa), 32'h1234_0000);

    // SRAV $11,$10,$9 with rs=0x24, rt=0x80000000
    issue({6'h00, 5'd9, 5'd10, 5'd11, 5'd0, 6'h07}, 32'h24, 32'h8000_0000);
    check("srav_sa", alu_sa, 5'd4);
    check("srav_res", alu(alu_op, alu_a, alu_b, alu_sa), 32'hF800_0000);

    // Backpressure: slot full, EX stalls 3 cycles while upstream keeps offering
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h2002_0007 + i, 32'h10, 32'h20, 1'b0, 1'b0);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_held_sa", alu_sa, 5'd4);
    end
    // Release: back-to-back stream, scoreboard catches loss or duplication
    for (int i = 0; i < 4; i++) issue(rand_instr(), $urandom(), $urandom());
    idle(1'b1);
    idle(1'b1);

    // Flush while full with a new instruction offered
    issue(32'h2128_0003, 32'd1, 32'd0);
    cycle(1'b1, 32'h2128_0009, 32'd1, 32'd0, 1'b1, 1'b0);
    check("flush_out_valid", out_valid, 1'b0);
    idle(1'b1);
    check("flush_dropped", out_valid, 1'b0);

    // Unsupported opcode 0x3F
    issue(32'hFD2A_0001, 32'h55, 32'h66);
    check("ill_flag", illegal, 1'b1);
    check("ill_reg_write", reg_write, 1'b0);
    check("ill_op", alu_op, ALU_ADDU);

    // Reset while full
    issue(32'h2128_0001, 32'd7, 32'd0);
    rst_n = 1'b0;
    idle(1'b0);
    check("rst_full_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom(), $urandom(),
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end
    idle(1'b1);
    idle(1'b1);
    check("drain_empty", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
